// File: rtl/dpram_arb_pkg.sv
// Shared types and constants for the dual-port RAM port arbiter.
// Optional conflict counter is enabled by DPRAM_ARB_CONFLICT_CNT_EN.
package dpram_arb_pkg;

  localparam int unsigned DEF_AW  = 6;
  localparam int unsigned DEF_DW  = 8;
  // Wide enough for the largest supported requester count (8).
  localparam int unsigned PEND_IW = 3;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_e;

  typedef struct packed {
    logic               valid;
    logic [PEND_IW-1:0] idx;
  } pend_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr_pick.sv
// Rotating find-first: first set bit of mask_i scanning start_i, start_i+1, ... modulo N.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found_o && mask_i[(32'(start_i) + k) % N]) begin
        found_o = 1'b1;
        idx_o   = IW'((32'(start_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing both ports of a dual-port RAM among NREQ requesters.
// Define DPRAM_ARB_CONFLICT_CNT_EN to add the saturating conflict_cnt output.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = DEF_AW,
  parameter int unsigned DW   = DEF_DW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [NREQ*DW-1:0] rdata,
  output logic [AW-1:0]      ram_addr_a,
  output logic [AW-1:0]      ram_addr_b,
  output logic [DW-1:0]      ram_data_a,
  output logic [DW-1:0]      ram_data_b,
  output logic               ram_we_a,
  output logic               ram_we_b,
  input  logic [DW-1:0]      ram_q_a,
  input  logic [DW-1:0]      ram_q_b
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]        conflict_cnt
`endif
);

  localparam int unsigned IW = idx_width(NREQ);

  logic [IW-1:0]   ptr_q, ptr_d;
  logic            found_a, found_b;
  logic [IW-1:0]   idx_a, idx_b, start_b;
  logic [NREQ-1:0] onehot_a, onehot_b, conf, mask_b;
  logic [AW-1:0]   addr_a_sel;
  logic            we_a_sel;
  pend_t           pend_q [2];
  pend_t           pend_d [2];

  rr_pick #(.N(NREQ), .IW(IW)) u_pick_a (
    .mask_i  (req),
    .start_i (ptr_q),
    .found_o (found_a),
    .idx_o   (idx_a)
  );

  assign start_b    = IW'((32'(idx_a) + 1) % NREQ);
  assign addr_a_sel = req_addr[idx_a*AW +: AW];
  assign we_a_sel   = req_we[idx_a];
  assign onehot_a   = found_a ? (NREQ'(1) << idx_a) : '0;

  // Conflicting requesters are removed from B's mask so the scan skips past them.
  always_comb begin
    conf = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      conf[i] = found_a && req[i] && (IW'(i) != idx_a)
                && (req_addr[i*AW +: AW] == addr_a_sel)
                && (req_we[i] || we_a_sel);
    end
  end

  assign mask_b = req & ~onehot_a & ~conf;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick_b (
    .mask_i  (mask_b),
    .start_i (start_b),
    .found_o (found_b),
    .idx_o   (idx_b)
  );

  assign onehot_b = found_b ? (NREQ'(1) << idx_b) : '0;
  assign gnt      = onehot_a | onehot_b;

  always_comb begin
    ram_addr_a = '0;
    ram_data_a = '0;
    ram_we_a   = 1'b0;
    ram_addr_b = '0;
    ram_data_b = '0;
    ram_we_b   = 1'b0;
    if (found_a) begin
      ram_addr_a = addr_a_sel;
      ram_data_a = req_wdata[idx_a*DW +: DW];
      ram_we_a   = we_a_sel;
    end
    if (found_b) begin
      ram_addr_b = req_addr[idx_b*AW +: AW];
      ram_data_b = req_wdata[idx_b*DW +: DW];
      ram_we_b   = req_we[idx_b];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found_b) begin
      ptr_d = IW'((32'(idx_b) + 1) % NREQ);
    end else if (found_a) begin
      ptr_d = start_b;
    end
    pend_d[PORT_A] = '{valid: found_a && !we_a_sel, idx: PEND_IW'(idx_a)};
    pend_d[PORT_B] = '{valid: found_b && !req_we[idx_b], idx: PEND_IW'(idx_b)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q          <= '0;
      pend_q[PORT_A] <= '0;
      pend_q[PORT_B] <= '0;
    end else begin
      ptr_q          <= ptr_d;
      pend_q[PORT_A] <= pend_d[PORT_A];
      pend_q[PORT_B] <= pend_d[PORT_B];
    end
  end

  // Pending slots are register outputs, so an async reset clears rvalid at once.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pend_q[PORT_A].valid && (pend_q[PORT_A].idx == PEND_IW'(i))) begin
        rvalid[i]          = 1'b1;
        rdata[i*DW +: DW]  = ram_q_a;
      end
      if (pend_q[PORT_B].valid && (pend_q[PORT_B].idx == PEND_IW'(i))) begin
        rvalid[i]          = 1'b1;
        rdata[i*DW +: DW]  = ram_q_b;
      end
    end
  end

`ifdef DPRAM_ARB_CONFLICT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((|conf) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a behavioural 64x8 registered-output RAM.
module tb_dpram_port_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 6;
  localparam int unsigned DW   = 8;

  logic             clk;
  logic             rst_n;
  logic [NREQ-1:0]    req, req_we, gnt, rvalid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata, rdata;
  logic [AW-1:0]      ram_addr_a, ram_addr_b;
  logic [DW-1:0]      ram_data_a, ram_data_b, ram_q_a, ram_q_b;
  logic               ram_we_a, ram_we_b;
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
  logic [15:0]        conflict_cnt;
`endif

  int unsigned n_checks;
  int unsigned n_fail;

  logic [DW-1:0] mem [64];

  dpram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .ram_addr_a (ram_addr_a),
    .ram_addr_b (ram_addr_b),
    .ram_data_a (ram_data_a),
    .ram_data_b (ram_data_b),
    .ram_we_a   (ram_we_a),
    .ram_we_b   (ram_we_b),
    .ram_q_a    (ram_q_a),
    .ram_q_b    (ram_q_b)
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
    ram_q_a <= mem[ram_addr_a];
    ram_q_b <= mem[ram_addr_b];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic put(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]               = 1'b1;
    req_we[i]            = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] rd(input int i);
    return rdata[i*DW +: DW];
  endfunction

  // Start a new cycle: inputs change just after the rising edge.
  task automatic next();
    @(posedge clk);
    #1;
    clr();
  endtask

  logic [NREQ-1:0] g4 [4];
  logic [NREQ-1:0] rv4 [5];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h80 | 8'(i);
    mem[20] = 8'hA5;
    ram_q_a = '0;
    ram_q_b = '0;
    clr();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // idle after reset
    for (int c = 0; c < 5; c++) begin
      next();
      @(negedge clk);
      chk("idle_gnt", 32'(gnt), 32'h0);
      chk("idle_rvalid", 32'(rvalid), 32'h0);
      chk("idle_we", 32'({ram_we_a, ram_we_b}), 32'h0);
    end

    // two writes in one cycle, ptr=0
    next(); put(0, 1'b1, 6'd5, 8'h12); put(1, 1'b1, 6'd9, 8'h34);
    @(negedge clk);
    chk("w2_gnt", 32'(gnt), 32'h3);
    chk("w2_a", 32'({ram_we_a, ram_addr_a, ram_data_a}), {17'h0, 1'b1, 6'd5, 8'h12});
    chk("w2_b", 32'({ram_we_b, ram_addr_b, ram_data_b}), {17'h0, 1'b1, 6'd9, 8'h34});
    next(); put(2, 1'b0, 6'd5, 8'h00);
    @(negedge clk);
    chk("rd5_gnt", 32'(gnt), 32'h4);
    chk("rd5_a", 32'({ram_we_a, ram_addr_a}), {25'h0, 1'b0, 6'd5});
    chk("rd5_b_idle", 32'({ram_we_b, ram_addr_b, ram_data_b}), 32'h0);
    chk("rd5_rv_early", 32'(rvalid), 32'h0);
    next();
    @(negedge clk);
    chk("rd5_gnt_idle", 32'(gnt), 32'h0);
    chk("rd5_rvalid", 32'(rvalid), 32'h4);
    chk("rd5_rdata", 32'(rd(2)), 32'h12);

    // write/write conflict on addr 7, ptr=3 so req3 wins first
    next(); put(0, 1'b1, 6'd7, 8'h55); put(3, 1'b1, 6'd7, 8'h66);
    @(negedge clk);
    chk("cf_gnt1", 32'(gnt), 32'h8);
    chk("cf_a1", 32'({ram_we_a, ram_data_a}), {23'h0, 1'b1, 8'h66});
    chk("cf_b1", 32'(ram_we_b), 32'h0);
    next(); put(0, 1'b1, 6'd7, 8'h55);
    @(negedge clk);
    chk("cf_gnt2", 32'(gnt), 32'h1);
    chk("cf_a2", 32'(ram_data_a), 32'h55);
    next(); put(3, 1'b0, 6'd7, 8'h00);
    @(negedge clk);
    chk("cf_rd_gnt", 32'(gnt), 32'h8);
    next();
    @(negedge clk);
    chk("cf_rd_rvalid", 32'(rvalid), 32'h8);
    chk("cf_rd_rdata", 32'(rd(3)), 32'h55);

    // all four read, ptr=0
    g4[0] = 4'h3; g4[1] = 4'hC; g4[2] = 4'h3; g4[3] = 4'hC;
    rv4[0] = 4'h0; rv4[1] = 4'h3; rv4[2] = 4'hC; rv4[3] = 4'h3; rv4[4] = 4'hC;
    for (int c = 0; c < 5; c++) begin
      next();
      if (c < 4) for (int i = 0; i < 4; i++) put(i, 1'b0, 6'(10 + i), 8'h00);
      @(negedge clk);
      chk($sformatf("all_gnt%0d", c), 32'(gnt), (c < 4) ? 32'(g4[c]) : 32'h0);
      chk($sformatf("all_rv%0d", c), 32'(rvalid), 32'(rv4[c]));
      for (int i = 0; i < 4; i++)
        if (rv4[c][i]) chk($sformatf("all_rd%0d_%0d", c, i), 32'(rd(i)), 32'h8A + 32'(i));
    end

    // read+read of the same address, ptr=0
    next(); put(1, 1'b0, 6'd20, 8'h00); put(2, 1'b0, 6'd20, 8'h00);
    @(negedge clk);
    chk("rr_gnt", 32'(gnt), 32'h6);
    chk("rr_addr", 32'({ram_addr_a, ram_addr_b}), {20'h0, 6'd20, 6'd20});
    next();
    @(negedge clk);
    chk("rr_rvalid", 32'(rvalid), 32'h6);
    chk("rr_rd1", 32'(rd(1)), 32'hA5);
    chk("rr_rd2", 32'(rd(2)), 32'hA5);
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
    chk("cnt_one", 32'(conflict_cnt), 32'h1);
`endif

    // reset between grant and response
    next(); put(0, 1'b0, 6'd5, 8'h00);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h1);
    @(posedge clk);
    #1;
    clr();
    rst_n = 1'b0;
    #1;
    chk("rst_rv_async", 32'(rvalid), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rv_after", 32'(rvalid), 32'h0);
    next(); put(0, 1'b0, 6'd1, 8'h00); put(2, 1'b0, 6'd2, 8'h00);
    @(negedge clk);
    chk("rst_ptr_gnt", 32'(gnt), 32'h5);
    chk("rst_ptr_addr", 32'({ram_addr_a, ram_addr_b}), {20'h0, 6'd1, 6'd2});
    chk("rst_rv_late", 32'(rvalid), 32'h0);
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
    chk("cnt_rst", 32'(conflict_cnt), 32'h0);
`endif
    next();
    @(negedge clk);
    chk("post_rvalid", 32'(rvalid), 32'h5);
    chk("post_rd0", 32'(rd(0)), 32'h81);
    chk("post_rd2", 32'(rd(2)), 32'h82);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
